// File: rtl/rst_seq_multi.sv
// Multi-channel reset sequencer: pulses active-low resets on all enabled channels,
// then releases them one by one in index order and signals completion with done_rst_o.
module rst_seq_multi #(
    parameter int N_CH         = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1,
    parameter bit HOLD_AT_POR  = 1'b0,
    parameter bit RETRIGGER    = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_rst_i,
    input  logic [N_CH-1:0] ch_en_i,
    output logic [N_CH-1:0] rst_out_o,
    output logic            busy_o,
    output logic            done_rst_o
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int SW = $clog2(N_CH + 1);

    localparam logic [PW-1:0]   PULSE_LAST = PW'(PULSE_CYCLES - 1);
    localparam logic [GW-1:0]   GAP_LAST   = GW'(GAP_CYCLES - 1);
    localparam logic [SW-1:0]   SLOT_LAST  = SW'(N_CH - 1);
    localparam logic [N_CH-1:0] RST_VAL    = {N_CH{!HOLD_AT_POR}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   mask_q, mask_d;
    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [GW-1:0]     gcnt_q, gcnt_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [N_CH-1:0]   rst_out_q, rst_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            pcnt_q    <= '0;
            gcnt_q    <= '0;
            slot_q    <= '0;
            rst_out_q <= RST_VAL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            pcnt_q    <= pcnt_d;
            gcnt_q    <= gcnt_d;
            slot_q    <= slot_d;
            rst_out_q <= rst_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // A start seen on the last DONE cycle re-arms directly so a held request
    // produces back-to-back sequences with a single non-busy cycle between them.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        pcnt_d  = pcnt_q;
        gcnt_d  = gcnt_q;
        slot_d  = slot_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rst_i) begin
                    state_d = ST_ASSERT;
                    mask_d  = ch_en_i;
                    pcnt_d  = '0;
                    gcnt_d  = '0;
                    slot_d  = '0;
                end
            end
            ST_ASSERT: begin
                if (pcnt_q == PULSE_LAST) begin
                    state_d = ST_RELEASE;
                    gcnt_d  = '0;
                    slot_d  = '0;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            ST_RELEASE: begin
                if (RETRIGGER && start_rst_i) begin
                    state_d = ST_ASSERT;
                    mask_d  = ch_en_i;
                    pcnt_d  = '0;
                    gcnt_d  = '0;
                    slot_d  = '0;
                end else if (gcnt_q == GAP_LAST) begin
                    gcnt_d = '0;
                    if (slot_q == SLOT_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        slot_d = slot_q + SW'(1);
                    end
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            ST_DONE: begin
                if (start_rst_i) begin
                    state_d = ST_ASSERT;
                    mask_d  = ch_en_i;
                    pcnt_d  = '0;
                    gcnt_d  = '0;
                    slot_d  = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are derived from the upcoming state and registered alongside it.
    always_comb begin
        rst_out_d = rst_out_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_d)
            ST_ASSERT: begin
                busy_d    = 1'b1;
                rst_out_d = rst_out_q & ~mask_d;
            end
            ST_RELEASE: begin
                busy_d = 1'b1;
                if (gcnt_d == '0) begin
                    for (int i = 0; i < N_CH; i++) begin
                        if ((slot_d == SW'(i)) && mask_d[i]) begin
                            rst_out_d[i] = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rst_out_o  = rst_out_q;
    assign busy_o     = busy_q;
    assign done_rst_o = done_q;

endmodule

// File: tb/tb_rst_seq_multi.sv
// Directed bench for rst_seq_multi: default, RETRIGGER=1 and HOLD_AT_POR=1 instances
// share the same stimulus and each scenario task checks the relevant instance(s).
module tb_rst_seq_multi;

    logic       clk;
    logic       rst;
    logic       startRst;
    logic [3:0] chEn;

    logic [3:0] rstOut0, rstOut1, rstOut2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;

    int checks = 0;
    int errors = 0;

    rst_seq_multi dut0 (
        .clk_i(clk), .rst_i(rst), .start_rst_i(startRst), .ch_en_i(chEn),
        .rst_out_o(rstOut0), .busy_o(busy0), .done_rst_o(done0)
    );

    rst_seq_multi #(.RETRIGGER(1'b1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_rst_i(startRst), .ch_en_i(chEn),
        .rst_out_o(rstOut1), .busy_o(busy1), .done_rst_o(done1)
    );

    rst_seq_multi #(.HOLD_AT_POR(1'b1)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_rst_i(startRst), .ch_en_i(chEn),
        .rst_out_o(rstOut2), .busy_o(busy2), .done_rst_o(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply_reset();
        startRst = 1'b0;
        chEn     = 4'h0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Start is sampled on edge T; the caller's next negedge observes cycle T+1.
    task automatic pulse_start(input logic [3:0] mask);
        @(negedge clk);
        startRst = 1'b1;
        chEn     = mask;
        @(posedge clk);
        #1 startRst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++;
        if (rstOut0 !== 4'hF) begin errors++; $display("[TB] FAIL reset_rst_out0: got %h expected %h", rstOut0, 4'hF); end
        checks++;
        if (rstOut2 !== 4'h0) begin errors++; $display("[TB] FAIL reset_rst_out_hold: got %h expected %h", rstOut2, 4'h0); end
        checks++;
        if ({busy0, done0, busy1, done1} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_busy_done: got %b expected %b", {busy0, done0, busy1, done1}, 4'b0000);
        end
    endtask

    task automatic test_full_mask();
        logic [3:0] expRst [8] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF};
        logic       expBusy[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
        logic       expDone[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        apply_reset();
        pulse_start(4'hF);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (rstOut0 !== expRst[k-1]) begin errors++; $display("[TB] FAIL full_rst_out k=%0d: got %h expected %h", k, rstOut0, expRst[k-1]); end
            checks++;
            if (rstOut2 !== expRst[k-1]) begin errors++; $display("[TB] FAIL full_rst_out_hold k=%0d: got %h expected %h", k, rstOut2, expRst[k-1]); end
            checks++;
            if (busy0 !== expBusy[k-1]) begin errors++; $display("[TB] FAIL full_busy k=%0d: got %b expected %b", k, busy0, expBusy[k-1]); end
            checks++;
            if (done0 !== expDone[k-1]) begin errors++; $display("[TB] FAIL full_done k=%0d: got %b expected %b", k, done0, expDone[k-1]); end
        end
    endtask

    task automatic test_partial_mask();
        logic [3:0] expRst [8] = '{4'hA, 4'hA, 4'hB, 4'hB, 4'hF, 4'hF, 4'hF, 4'hF};
        apply_reset();
        pulse_start(4'b0101);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (rstOut0 !== expRst[k-1]) begin errors++; $display("[TB] FAIL partial_rst_out k=%0d: got %h expected %h", k, rstOut0, expRst[k-1]); end
            checks++;
            if (done0 !== (k == 7)) begin errors++; $display("[TB] FAIL partial_done k=%0d: got %b expected %b", k, done0, (k == 7)); end
        end
    endtask

    task automatic test_empty_mask();
        apply_reset();
        pulse_start(4'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (rstOut0 !== 4'hF) begin errors++; $display("[TB] FAIL empty_rst_out k=%0d: got %h expected %h", k, rstOut0, 4'hF); end
            checks++;
            if (busy0 !== (k <= 6)) begin errors++; $display("[TB] FAIL empty_busy k=%0d: got %b expected %b", k, busy0, (k <= 6)); end
            checks++;
            if (done0 !== (k == 7)) begin errors++; $display("[TB] FAIL empty_done k=%0d: got %b expected %b", k, done0, (k == 7)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] tbl [7] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF};
        apply_reset();
        @(negedge clk);
        startRst = 1'b1;
        chEn     = 4'hF;
        @(posedge clk);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            checks++;
            if (rstOut0 !== tbl[(k-1) % 7]) begin errors++; $display("[TB] FAIL b2b_rst_out k=%0d: got %h expected %h", k, rstOut0, tbl[(k-1) % 7]); end
            checks++;
            if (busy0 !== ((k % 7) != 0)) begin errors++; $display("[TB] FAIL b2b_busy k=%0d: got %b expected %b", k, busy0, ((k % 7) != 0)); end
            checks++;
            if (done0 !== ((k % 7) == 0)) begin errors++; $display("[TB] FAIL b2b_done k=%0d: got %b expected %b", k, done0, ((k % 7) == 0)); end
            if (k == 14) startRst = 1'b0;
        end
        @(negedge clk);
        checks++;
        if ({busy0, done0, rstOut0} !== 6'b00_1111) begin
            errors++; $display("[TB] FAIL b2b_idle: got %b expected %b", {busy0, done0, rstOut0}, 6'b00_1111);
        end
    endtask

    task automatic test_retrigger();
        logic [3:0] exp0 [12] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
        logic [3:0] exp1 [12] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF};
        apply_reset();
        pulse_start(4'hF);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (rstOut0 !== exp0[k-1]) begin errors++; $display("[TB] FAIL retrig0_rst_out k=%0d: got %h expected %h", k, rstOut0, exp0[k-1]); end
            checks++;
            if (done0 !== (k == 7)) begin errors++; $display("[TB] FAIL retrig0_done k=%0d: got %b expected %b", k, done0, (k == 7)); end
            checks++;
            if (rstOut1 !== exp1[k-1]) begin errors++; $display("[TB] FAIL retrig1_rst_out k=%0d: got %h expected %h", k, rstOut1, exp1[k-1]); end
            checks++;
            if (busy1 !== (k <= 10)) begin errors++; $display("[TB] FAIL retrig1_busy k=%0d: got %b expected %b", k, busy1, (k <= 10)); end
            checks++;
            if (done1 !== (k == 11)) begin errors++; $display("[TB] FAIL retrig1_done k=%0d: got %b expected %b", k, done1, (k == 11)); end
            if (k == 4) startRst = 1'b1;
            if (k == 5) startRst = 1'b0;
        end
    endtask

    task automatic test_hold_at_por();
        logic [3:0] expRst [7] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h6, 4'h6, 4'h6};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (rstOut2 !== 4'h0) begin errors++; $display("[TB] FAIL hold_idle k=%0d: got %h expected %h", k, rstOut2, 4'h0); end
        end
        pulse_start(4'b0110);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (rstOut2 !== expRst[k-1]) begin errors++; $display("[TB] FAIL hold_rst_out k=%0d: got %h expected %h", k, rstOut2, expRst[k-1]); end
            checks++;
            if (done2 !== (k == 7)) begin errors++; $display("[TB] FAIL hold_done k=%0d: got %b expected %b", k, done2, (k == 7)); end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] expRst [7] = '{4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hF};
        apply_reset();
        pulse_start(4'hF);
        repeat (4) @(negedge clk);
        checks++;
        if (rstOut0 !== 4'h3) begin errors++; $display("[TB] FAIL midrst_before: got %h expected %h", rstOut0, 4'h3); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rstOut0, busy0, done0} !== 6'b1111_00) begin
            errors++; $display("[TB] FAIL midrst_async0: got %b expected %b", {rstOut0, busy0, done0}, 6'b1111_00);
        end
        checks++;
        if ({rstOut2, busy2, done2} !== 6'b0000_00) begin
            errors++; $display("[TB] FAIL midrst_async_hold: got %b expected %b", {rstOut2, busy2, done2}, 6'b0000_00);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if ({busy0, done0, rstOut0} !== 6'b00_1111) begin
                errors++; $display("[TB] FAIL midrst_quiet k=%0d: got %b expected %b", k, {busy0, done0, rstOut0}, 6'b00_1111);
            end
        end
        pulse_start(4'hF);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checks++;
            if (rstOut0 !== expRst[k-1]) begin errors++; $display("[TB] FAIL midrst_resume_rst_out k=%0d: got %h expected %h", k, rstOut0, expRst[k-1]); end
            checks++;
            if (done0 !== (k == 7)) begin errors++; $display("[TB] FAIL midrst_resume_done k=%0d: got %b expected %b", k, done0, (k == 7)); end
        end
    endtask

    initial begin
        rst      = 1'b1;
        startRst = 1'b0;
        chEn     = 4'h0;
        test_reset();
        test_full_mask();
        test_partial_mask();
        test_empty_mask();
        test_back_to_back();
        test_retrigger();
        test_hold_at_por();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
